id_ex_hazard_ctrl: RTL

Pipeline hazard controller that sequences the ID/EX pipeline register and the stages around it. It detects load-use hazards, tracks the multi-cycle multiply/divide unit, and resolves taken branches. From these it generates the PC/IF-ID hold, IF-ID flush and ID/EX bubble controls. It sits between the decode stage and the `id_ex` register, beside the forwarding logic.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/muldiv_tracker.sv | 56 +++++
 rtl/id_ex_hazard_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard-controller state encoding, register
// constants and the MIPS opcode/func codes the decoder uses to drive
// id_is_muldiv and id_uses_hilo.
package pipe_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned MD_CNT_W = 4;
    localparam int unsigned OPC_W   = 6;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } haz_state_t;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    localparam logic [OPC_W-1:0] OP_SPECIAL = 6'h00;
    localparam logic [OPC_W-1:0] FN_MFHI    = 6'h10;
    localparam logic [OPC_W-1:0] FN_MTHI    = 6'h11;
    localparam logic [OPC_W-1:0] FN_MFLO    = 6'h12;
    localparam logic [OPC_W-1:0] FN_MTLO    = 6'h13;
    localparam logic [OPC_W-1:0] FN_MULT    = 6'h18;
    localparam logic [OPC_W-1:0] FN_MULTU   = 6'h19;
    localparam logic [OPC_W-1:0] FN_DIV     = 6'h1a;
    localparam logic [OPC_W-1:0] FN_DIVU    = 6'h1b;

    // Decoder helper: SPECIAL-class instruction that occupies the mult/div unit.
    function automatic logic is_muldiv_op(input logic [OPC_W-1:0] opc,
                                          input logic [OPC_W-1:0] fn);
        return (opc == OP_SPECIAL) &&
               (fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
    endfunction

    // Decoder helper: SPECIAL-class instruction that moves to/from HI or LO.
    function automatic logic is_hilo_op(input logic [OPC_W-1:0] opc,
                                        input logic [OPC_W-1:0] fn);
        return (opc == OP_SPECIAL) &&
               (fn == FN_MFHI || fn == FN_MTHI || fn == FN_MFLO || fn == FN_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// Tracks occupancy of the multi-cycle mult/div unit: RUN/MD_BUSY state,
// a down-counter of remaining busy cycles and a registered busy flag.
module muldiv_tracker
    import pipe_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic muldiv_busy
);

    haz_state_t            state_q;
    haz_state_t            state_d;
    logic [MD_CNT_W-1:0]   md_cnt_q;
    logic [MD_CNT_W-1:0]   md_cnt_d;

    // State, counter and busy flag registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            md_cnt_q    <= '0;
            muldiv_busy <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            muldiv_busy <= (state_d == MD_BUSY);
        end
    end

    // Next state: issue loads LAT-1 busy cycles; leave MD_BUSY after the last one.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (issue) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_CNT_W'(MULDIV_LAT - 1);
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                if (md_cnt_q == MD_CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d  = RUN;
                md_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use and HI/LO stall detection, taken-branch
// flush and the resulting PC/IF-ID hold, IF-ID flush and ID/EX bubble.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module id_ex_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_valid,
    input  logic             id_is_muldiv,
    input  logic             id_uses_hilo,
    input  logic             ex_wr_en,
    input  logic [REG_W-1:0] ex_wr_num,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]      perf_lu_stalls,
    output logic [31:0]      perf_hl_stalls,
    output logic [31:0]      perf_flushes,
`endif
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             muldiv_busy
);

    logic lu_c;
    logic hl_c;
    logic issue_c;

    // Hazard detection; a load to $0 never stalls.
    always_comb begin
        lu_c = ex_is_load && ex_wr_en && (ex_wr_num != REG_ZERO) && id_valid &&
               ((ex_wr_num == id_rs) || (id_uses_rt && (ex_wr_num == id_rt)));
        hl_c = muldiv_busy && id_valid && (id_is_muldiv || id_uses_hilo);
        issue_c = !muldiv_busy && id_valid && id_is_muldiv &&
                  !ex_branch_taken && !lu_c;
    end

    // Pipeline controls: reset, then branch flush, then stall.
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (lu_c || hl_c) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    muldiv_tracker #(
        .MULDIV_LAT (MULDIV_LAT)
    ) u_muldiv_tracker (
        .clk         (clk),
        .rst         (rst),
        .issue       (issue_c),
        .muldiv_busy (muldiv_busy)
    );

`ifdef HAZ_PERF_CNT_EN
    logic flush_win_c;
    logic lu_win_c;
    logic hl_win_c;

    // Winning cause of this cycle's control action.
    always_comb begin
        flush_win_c = ex_branch_taken;
        lu_win_c    = !ex_branch_taken && lu_c;
        hl_win_c    = !ex_branch_taken && !lu_c && hl_c;
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stalls <= '0;
            perf_hl_stalls <= '0;
            perf_flushes   <= '0;
        end else begin
            if (lu_win_c && (perf_lu_stalls != '1)) begin
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            end
            if (hl_win_c && (perf_hl_stalls != '1)) begin
                perf_hl_stalls <= perf_hl_stalls + 32'd1;
            end
            if (flush_win_c && (perf_flushes != '1)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule
